// File: rtl/gbt_link_init_seq.sv
// gbt_link_init_seq: optical-link bring-up sequencer (QPLL -> GTX -> GBT) with per-phase timeouts and bounded retries
module gbt_link_init_seq #(
    parameter int          QPLL_RST_LEN = 16,
    parameter int          GTX_RST_LEN  = 16,
    parameter logic [19:0] WAIT_TMO     = 20'hFFFFF,
    parameter int          MAX_RETRY    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic       QPLL_LOCK,
    input  logic       TX_RST_DONE,
    input  logic       RX_RST_DONE,
    input  logic       RX_ALIGNED,
    input  logic       RESYNC,
    output logic       QPLL_RST,
    output logic       GTX_TX_RST,
    output logic       GTX_RX_RST,
    output logic       GBT_RST,
    output logic       LINK_READY,
    output logic       INIT_FAIL,
    output logic [3:0] RETRY_CNT,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_QPLL_RST  = 3'd1,
        S_W4QPLL    = 3'd2,
        S_GTX_RST   = 3'd3,
        S_W4RSTDONE = 3'd4,
        S_W4ALIGN   = 3'd5,
        S_READY     = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    localparam logic [19:0] Q_END = 20'(QPLL_RST_LEN - 1);
    localparam logic [19:0] G_END = 20'(GTX_RST_LEN - 1);
    localparam logic [19:0] T_END = WAIT_TMO - 20'd1;
    localparam logic [3:0]  R_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [4:0]  out_q, out_d;
    logic        tmo;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        tmo     = 1'b0;
        if (state_q != S_IDLE && !RUN) begin
            state_d = S_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE:      state_d = RUN ? S_QPLL_RST : S_IDLE;
                S_QPLL_RST:  if (timer_q == Q_END) state_d = S_W4QPLL;
                S_W4QPLL:    if (QPLL_LOCK) state_d = S_GTX_RST; else tmo = (timer_q == T_END);
                S_GTX_RST:   if (!QPLL_LOCK) state_d = S_QPLL_RST; else if (timer_q == G_END) state_d = S_W4RSTDONE;
                S_W4RSTDONE: if (TX_RST_DONE && RX_RST_DONE) state_d = S_W4ALIGN; else tmo = (timer_q == T_END);
                S_W4ALIGN:   if (RX_ALIGNED) state_d = S_READY; else tmo = (timer_q == T_END);
                S_READY:     if (!QPLL_LOCK) state_d = S_QPLL_RST; else if (!RX_ALIGNED || RESYNC) state_d = S_GTX_RST;
                S_FAIL:      if (RESYNC) begin state_d = S_QPLL_RST; retry_d = '0; end
                default:     state_d = S_IDLE;
            endcase
        end
        // retry budget exhausted parks in Fail with the count held at its ceiling
        if (tmo) begin
            state_d = (retry_q == R_MAX) ? S_FAIL : S_QPLL_RST;
            retry_d = (retry_q == R_MAX) ? retry_q : retry_q + 4'd1;
        end
        if (state_d == S_READY && state_q != S_READY) retry_d = '0;
        timer_d = (state_d != state_q) ? '0 : timer_q + {19'd0, ~&timer_q};
        case (state_d)
            S_IDLE, S_QPLL_RST:    out_d = 5'b11100;
            S_W4QPLL, S_GTX_RST:   out_d = 5'b01100;
            S_W4RSTDONE:           out_d = 5'b00100;
            S_W4ALIGN:             out_d = 5'b00000;
            S_READY:               out_d = 5'b00010;
            default:               out_d = 5'b11101;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
            out_q   <= 5'b11100;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign QPLL_RST   = out_q[4];
    assign GTX_TX_RST = out_q[3];
    assign GTX_RX_RST = out_q[3];
    assign GBT_RST    = out_q[2];
    assign LINK_READY = out_q[1];
    assign INIT_FAIL  = out_q[0];
    assign RETRY_CNT  = retry_q;
    assign STATE      = state_q;
endmodule

// File: tb/tb_gbt_link_init_seq.sv
// tb_gbt_link_init_seq: directed bring-up scenarios checked every cycle against a phase/cycle-count model
module tb_gbt_link_init_seq;
    localparam int QL = 4;
    localparam int GL = 4;
    localparam int TMO = 32;
    localparam int MR = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1, RUN = 1'b1, QPLL_LOCK = 1'b0, TX_RST_DONE = 1'b0, RX_RST_DONE = 1'b0;
    logic RX_ALIGNED = 1'b0, RESYNC = 1'b0;
    logic QPLL_RST, GTX_TX_RST, GTX_RX_RST, GBT_RST, LINK_READY, INIT_FAIL;
    logic [3:0] RETRY_CNT;
    logic [2:0] STATE;

    int nchk = 0, nerr = 0;

    gbt_link_init_seq #(
        .QPLL_RST_LEN(QL), .GTX_RST_LEN(GL), .WAIT_TMO(20'(TMO)), .MAX_RETRY(MR)
    ) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .QPLL_LOCK(QPLL_LOCK), .TX_RST_DONE(TX_RST_DONE),
        .RX_RST_DONE(RX_RST_DONE), .RX_ALIGNED(RX_ALIGNED), .RESYNC(RESYNC),
        .QPLL_RST(QPLL_RST), .GTX_TX_RST(GTX_TX_RST), .GTX_RX_RST(GTX_RX_RST), .GBT_RST(GBT_RST),
        .LINK_READY(LINK_READY), .INIT_FAIL(INIT_FAIL), .RETRY_CNT(RETRY_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase number, cycles spent in it, timeouts used; outputs looked up per phase
    int ms = 0, mc = 0, mr = 0;
    bit mvalid = 1'b0;
    logic [4:0] otab [8] = '{5'b11100, 5'b11100, 5'b01100, 5'b01100, 5'b00100, 5'b00000, 5'b00010, 5'b11101};

    always @(posedge CLK) begin
        int ns, nr;
        bit to, hit;
        if (RST) begin
            ms = 0; mc = 0; mr = 0; mvalid = 1'b1;
        end else begin
            ns = ms; nr = mr; hit = 1'b0;
            to = (mc == TMO - 1);
            if (ms != 0 && !RUN) begin ns = 0; nr = 0; end
            else if (ms == 0) ns = 1;
            else if (ms == 1) begin if (mc == QL - 1) ns = 2; end
            else if (ms == 2) begin if (QPLL_LOCK) ns = 3; else hit = to; end
            else if (ms == 3) begin if (!QPLL_LOCK) ns = 1; else if (mc == GL - 1) ns = 4; end
            else if (ms == 4) begin if (TX_RST_DONE && RX_RST_DONE) ns = 5; else hit = to; end
            else if (ms == 5) begin if (RX_ALIGNED) ns = 6; else hit = to; end
            else if (ms == 6) begin if (!QPLL_LOCK) ns = 1; else if (!RX_ALIGNED || RESYNC) ns = 3; end
            else if (RESYNC) begin ns = 1; nr = 0; end
            if (hit) begin
                if (mr >= MR) ns = 7;
                else begin ns = 1; nr = mr + 1; end
            end
            if (ns == 6 && ms != 6) nr = 0;
            mc = (ns != ms) ? 0 : mc + 1;
            ms = ns; mr = nr;
        end
    end

    always @(negedge CLK) begin
        if (mvalid) begin
            chk("state", int'(STATE), ms);
            chk("qpll_rst", int'(QPLL_RST), int'(otab[ms][4]));
            chk("gtx_tx_rst", int'(GTX_TX_RST), int'(otab[ms][3]));
            chk("gtx_rx_rst", int'(GTX_RX_RST), int'(otab[ms][3]));
            chk("gbt_rst", int'(GBT_RST), int'(otab[ms][2]));
            chk("link_ready", int'(LINK_READY), int'(otab[ms][1]));
            chk("init_fail", int'(INIT_FAIL), int'(otab[ms][0]));
            chk("retry_cnt", int'(RETRY_CNT), mr);
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_st(input int s, input int mx, output int n, output int hq, output int hg);
        n = 0; hq = 0; hg = 0;
        do begin
            @(negedge CLK);
            n++;
            if (QPLL_RST) hq++;
            if (GTX_TX_RST) hg++;
        end while (int'(STATE) != s && n < mx);
        chk("reach_state", int'(STATE), s);
    endtask

    initial begin
        int n, hq, hg;
        // 1: clean bring-up
        repeat (3) step();
        chk("rst_state", int'(STATE), 0);
        chk("rst_resets", int'({QPLL_RST, GTX_TX_RST, GTX_RX_RST, GBT_RST}), 15);
        chk("rst_retry", int'(RETRY_CNT), 0);
        RST = 1'b0;
        wait_st(2, 20, n, hq, hg);
        chk("qpll_rst_cycles", hq, 4);
        repeat (4) step();
        QPLL_LOCK = 1'b1;
        wait_st(4, 20, n, hq, hg);
        chk("gtx_rst_cycles", hg, 4);
        chk("qpll_low_in_gtx", hq, 0);
        repeat (2) step();
        TX_RST_DONE = 1'b1; RX_RST_DONE = 1'b1;
        wait_st(5, 20, n, hq, hg);
        repeat (9) step();
        RX_ALIGNED = 1'b1;
        wait_st(6, 20, n, hq, hg);
        chk("ready_link", int'(LINK_READY), 1);
        chk("ready_retry", int'(RETRY_CNT), 0);
        // 3: one-cycle alignment loss
        RX_ALIGNED = 1'b0; step(); RX_ALIGNED = 1'b1;
        chk("realign_state", int'(STATE), 3);
        chk("realign_link", int'(LINK_READY), 0);
        wait_st(6, 20, n, hq, hg);
        chk("realign_gtx_cycles", hg + 1, 4);
        chk("realign_qpll", hq, 0);
        // 5a: RESYNC together with alignment loss
        RX_ALIGNED = 1'b0; RESYNC = 1'b1; step(); RX_ALIGNED = 1'b1; RESYNC = 1'b0;
        chk("resync_state", int'(STATE), 3);
        wait_st(6, 20, n, hq, hg);
        chk("resync_gtx_cycles", hg + 1, 4);
        // 4: QPLL lock loss in Ready
        QPLL_LOCK = 1'b0; step();
        chk("lockloss_state", int'(STATE), 1);
        chk("lockloss_qpll", int'(QPLL_RST), 1);
        QPLL_LOCK = 1'b1;
        wait_st(6, 30, n, hq, hg);
        chk("relock_retry", int'(RETRY_CNT), 0);
        // 5b: alignment arrives on the timeout cycle
        RX_ALIGNED = 1'b0; step();
        wait_st(5, 20, n, hq, hg);
        repeat (31) step();
        chk("pre_timeout_state", int'(STATE), 5);
        RX_ALIGNED = 1'b1; step();
        chk("late_align_state", int'(STATE), 6);
        chk("late_align_retry", int'(RETRY_CNT), 0);
        // 2: QPLL never locks -> retries then Fail
        QPLL_LOCK = 1'b0; step();
        wait_st(2, 20, n, hq, hg);
        wait_st(1, 60, n, hq, hg);
        chk("w4qpll_cycles", n, 32);
        chk("retry_1", int'(RETRY_CNT), 1);
        wait_st(2, 20, n, hq, hg);
        wait_st(1, 60, n, hq, hg);
        chk("retry_2", int'(RETRY_CNT), 2);
        wait_st(7, 60, n, hq, hg);
        chk("fail_flag", int'(INIT_FAIL), 1);
        chk("fail_resets", int'({QPLL_RST, GTX_TX_RST, GTX_RX_RST, GBT_RST}), 15);
        chk("fail_retry", int'(RETRY_CNT), 2);
        QPLL_LOCK = 1'b1;
        repeat (5) step();
        chk("fail_sticky", int'(STATE), 7);
        RESYNC = 1'b1; step(); RESYNC = 1'b0;
        chk("fail_exit_state", int'(STATE), 1);
        chk("fail_exit_retry", int'(RETRY_CNT), 0);
        chk("fail_exit_flag", int'(INIT_FAIL), 0);
        wait_st(6, 30, n, hq, hg);
        // 6: RUN low in W4RstDone, RST in GTX_Rst
        TX_RST_DONE = 1'b0; RX_RST_DONE = 1'b0; RX_ALIGNED = 1'b0;
        wait_st(4, 20, n, hq, hg);
        wait_st(1, 40, n, hq, hg);
        chk("rstdone_timeout_retry", int'(RETRY_CNT), 1);
        wait_st(4, 20, n, hq, hg);
        RUN = 1'b0; step();
        chk("runlow_state", int'(STATE), 0);
        chk("runlow_resets", int'({QPLL_RST, GTX_TX_RST, GTX_RX_RST, GBT_RST}), 15);
        chk("runlow_retry", int'(RETRY_CNT), 0);
        RUN = 1'b1;
        wait_st(3, 20, n, hq, hg);
        RST = 1'b1; step();
        chk("midrst_state", int'(STATE), 0);
        chk("midrst_gbt", int'(GBT_RST), 1);
        RST = 1'b0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
